sseg_scan_driver: RTL

Multiplexed multi-digit seven-segment display driver: it latches a packed hexadecimal value and scans its digits onto a shared segment bus, one digit at a time, with registered anode selects. It generalises the single-digit hex-to-segment decoder with:
- parametrised digit count
- a programmable refresh rate
- selectable output polarity
- decimal points
- leading-zero blanking
- a scan-complete strobe

It sits between datapath/register logic and the board's display pins.

---
 rtl/sseg_scan_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_driver.sv
// Multiplexed DIGITS-wide seven-segment scan driver with shadowed value, dp, leading-zero blanking.
// Latency: sseg/dp/an/scan_done are registered, lagging index changes and shadow loads by one cycle.
// No backpressure: load is accepted unconditionally; enable=0 freezes the scan and blanks the display.
module sseg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  blank_lz,
    output logic [6:0]            sseg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  scan_done
);

    // Elaboration-time rejection of illegal parameterisations.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("sseg_scan_driver: DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 1) begin : g_bad_refresh
        $error("sseg_scan_driver: REFRESH_DIV must be >= 1");
    end

    // Counter and index widths never collapse to zero bits.
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    // Off-state encodings for each output polarity.
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Hex digit to glyph, returned as the active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex_glyph_n(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dp;
    logic                  wrap_pend;

    logic                  cnt_last;
    logic                  idx_last;
    logic [DIGITS-1:0]     zero_mask;
    logic [DIGITS-1:0]     sel;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_zero;
    logic                  cur_blank;
    logic [6:0]            glyph_n;
    logic                  dp_lit;
    logic [6:0]            sseg_next;
    logic                  dp_next;
    logic [DIGITS-1:0]     an_next;

    assign cnt_last = (cnt == CNT_MAX);
    assign idx_last = (idx == IDX_MAX);

    // Digit i is a leading zero when it and every more-significant shadow nibble are zero; digit 0 never is.
    always_comb begin
        zero_mask = '0;
        for (int i = 1; i < DIGITS; i++) begin
            zero_mask[i] = 1'b1;
            for (int j = i; j < DIGITS; j++) begin
                if (shadow_val[4*j +: 4] != 4'h0) begin
                    zero_mask[i] = 1'b0;
                end
            end
        end
    end

    // Select the current digit's nibble, dp request and leading-zero flag from the shadow.
    always_comb begin
        sel      = '0;
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                sel[i]   = 1'b1;
                cur_nib  = shadow_val[4*i +: 4];
                cur_dp   = shadow_dp[i];
                cur_zero = zero_mask[i];
            end
        end
    end

    // Map the selected digit to pin-level values; a blanked digit keeps its anode but lights nothing.
    always_comb begin
        cur_blank = blank_lz & cur_zero;
        glyph_n   = cur_blank ? 7'h7F : hex_glyph_n(cur_nib);
        dp_lit    = cur_dp & ~cur_blank;
        sseg_next = SEG_ACTIVE_LOW ? glyph_n : ~glyph_n;
        dp_next   = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
        an_next   = AN_ACTIVE_LOW ? ~sel : sel;
    end

    // Shadow registers: the display only ever shows these, loaded whenever load is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
        end
    end

    // Refresh counter and digit index; wrap_pend remembers a full-scan wrap so scan_done lines up with digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            wrap_pend <= 1'b0;
        end else if (enable) begin
            wrap_pend <= cnt_last & idx_last;
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx_last ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Output registers sample the pre-edge index/shadow; disabled means everything dark and no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg      <= SEG_OFF;
            dp        <= DP_OFF;
            an        <= AN_OFF;
            scan_done <= 1'b0;
        end else if (enable) begin
            sseg      <= sseg_next;
            dp        <= dp_next;
            an        <= an_next;
            scan_done <= wrap_pend;
        end else begin
            sseg      <= SEG_OFF;
            dp        <= DP_OFF;
            an        <= AN_OFF;
            scan_done <= 1'b0;
        end
    end

endmodule
